// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request, register-file write and scoreboard query signals for regfile_wb_arbiter.
// The slave modport is the arbiter; the master modport is the requester/decode side.
interface regfile_wb_arbiter_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  // Requester A (ALU / branch-link writeback)
  logic                  a_valid;
  logic                  a_ready;
  logic [REG_ADDR_W-1:0] a_rd;
  logic [XLEN-1:0]       a_data;

  // Requester B (load-unit writeback)
  logic                  b_valid;
  logic                  b_ready;
  logic [REG_ADDR_W-1:0] b_rd;
  logic [XLEN-1:0]       b_data;

  // Register-file write port
  logic                  rf_write_en;
  logic [REG_ADDR_W-1:0] rf_rd;
  logic [XLEN-1:0]       rf_write_data;

  // Decode-stage scoreboard queries
  logic [REG_ADDR_W-1:0] q_rs1;
  logic [REG_ADDR_W-1:0] q_rs2;
  logic                  q_busy1;
  logic                  q_busy2;
  logic                  q_fwd_valid1;
  logic [XLEN-1:0]       q_fwd_data1;
  logic                  q_fwd_valid2;
  logic [XLEN-1:0]       q_fwd_data2;

  modport slave (
    input  a_valid, a_rd, a_data,
    output a_ready,
    input  b_valid, b_rd, b_data,
    output b_ready,
    output rf_write_en, rf_rd, rf_write_data,
    input  q_rs1, q_rs2,
    output q_busy1, q_busy2,
    output q_fwd_valid1, q_fwd_data1, q_fwd_valid2, q_fwd_data2
  );

  modport master (
    output a_valid, a_rd, a_data,
    input  a_ready,
    output b_valid, b_rd, b_data,
    input  b_ready,
    input  rf_write_en, rf_rd, rf_write_data,
    output q_rs1, q_rs2,
    input  q_busy1, q_busy2,
    input  q_fwd_valid1, q_fwd_data1, q_fwd_valid2, q_fwd_data2
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for a single-write-port register file: two one-entry holds, round-robin
// grant with age override on same-rd conflicts, plus a pending-write scoreboard.
// Optional forwarding of held data to decode is enabled by defining REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } hold_t;

  hold_t r_hold_a;
  hold_t r_hold_b;
  logic  r_rr_ptr;   // 0: A favoured on a distinct-rd conflict
  logic  r_age;      // 1: hold_b was loaded before hold_a

  logic w_grant_a;
  logic w_grant_b;
  logic w_a_ready;
  logic w_b_ready;
  logic w_a_load;
  logic w_b_load;
  logic w_a_stay;
  logic w_b_stay;

  // Grant decision uses only the hold flops
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (r_hold_a.valid && r_hold_b.valid) begin
      if (r_hold_a.rd == r_hold_b.rd) begin
        if (r_age) w_grant_b = 1'b1;
        else       w_grant_a = 1'b1;
      end else if (r_rr_ptr) begin
        w_grant_b = 1'b1;
      end else begin
        w_grant_a = 1'b1;
      end
    end else begin
      w_grant_a = r_hold_a.valid;
      w_grant_b = r_hold_b.valid;
    end
  end

  // Accept whenever the hold is empty or being drained this cycle; x0 entries are dropped
  always_comb begin
    w_a_ready = !rst && (!r_hold_a.valid || w_grant_a);
    w_b_ready = !rst && (!r_hold_b.valid || w_grant_b);
    w_a_load  = bus.a_valid && w_a_ready && (bus.a_rd != '0);
    w_b_load  = bus.b_valid && w_b_ready && (bus.b_rd != '0);
    w_a_stay  = r_hold_a.valid && !w_grant_a;
    w_b_stay  = r_hold_b.valid && !w_grant_b;
  end

  assign bus.a_ready = w_a_ready;
  assign bus.b_ready = w_b_ready;

  // Hold registers, round-robin pointer and relative age
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_a <= '0;
      r_hold_b <= '0;
      r_rr_ptr <= 1'b0;
      r_age    <= 1'b0;
    end else begin
      if (w_a_load) begin
        r_hold_a <= '{valid: 1'b1, rd: bus.a_rd, data: bus.a_data};
      end else if (w_grant_a) begin
        r_hold_a.valid <= 1'b0;
      end

      if (w_b_load) begin
        r_hold_b <= '{valid: 1'b1, rd: bus.b_rd, data: bus.b_data};
      end else if (w_grant_b) begin
        r_hold_b.valid <= 1'b0;
      end

      if (w_grant_a) begin
        r_rr_ptr <= 1'b1;
      end else if (w_grant_b) begin
        r_rr_ptr <= 1'b0;
      end

      // Simultaneous loads count B as older
      if (w_a_load && (w_b_load || w_b_stay)) begin
        r_age <= 1'b1;
      end else if (w_b_load && w_a_stay) begin
        r_age <= 1'b0;
      end
    end
  end

  logic [REG_ADDR_W-1:0] w_rf_rd;
  logic [XLEN-1:0]       w_rf_data;

  always_comb begin
    w_rf_rd   = '0;
    w_rf_data = '0;
    if (w_grant_a) begin
      w_rf_rd   = r_hold_a.rd;
      w_rf_data = r_hold_a.data;
    end else if (w_grant_b) begin
      w_rf_rd   = r_hold_b.rd;
      w_rf_data = r_hold_b.data;
    end
  end

  assign bus.rf_write_en   = w_grant_a || w_grant_b;
  assign bus.rf_rd         = w_rf_rd;
  assign bus.rf_write_data = w_rf_data;

  logic w_m1a;
  logic w_m1b;
  logic w_m2a;
  logic w_m2b;
  logic w_busy1;
  logic w_busy2;

  // Scoreboard: any valid hold, including the one being granted, marks its rd busy
  always_comb begin
    w_m1a   = r_hold_a.valid && (r_hold_a.rd == bus.q_rs1);
    w_m1b   = r_hold_b.valid && (r_hold_b.rd == bus.q_rs1);
    w_m2a   = r_hold_a.valid && (r_hold_a.rd == bus.q_rs2);
    w_m2b   = r_hold_b.valid && (r_hold_b.rd == bus.q_rs2);
    w_busy1 = (bus.q_rs1 != '0) && (w_m1a || w_m1b);
    w_busy2 = (bus.q_rs2 != '0) && (w_m2a || w_m2b);
  end

  assign bus.q_busy1 = w_busy1;
  assign bus.q_busy2 = w_busy2;

`ifdef REGFILE_WB_BYPASS_EN
  logic [XLEN-1:0] w_fwd1;
  logic [XLEN-1:0] w_fwd2;

  // When both holds match, the younger entry carries the architecturally newest value
  always_comb begin
    w_fwd1 = '0;
    w_fwd2 = '0;
    if (w_busy1) begin
      if (w_m1a && w_m1b) w_fwd1 = r_age ? r_hold_a.data : r_hold_b.data;
      else if (w_m1a)     w_fwd1 = r_hold_a.data;
      else                w_fwd1 = r_hold_b.data;
    end
    if (w_busy2) begin
      if (w_m2a && w_m2b) w_fwd2 = r_age ? r_hold_a.data : r_hold_b.data;
      else if (w_m2a)     w_fwd2 = r_hold_a.data;
      else                w_fwd2 = r_hold_b.data;
    end
  end

  assign bus.q_fwd_valid1 = w_busy1;
  assign bus.q_fwd_data1  = w_fwd1;
  assign bus.q_fwd_valid2 = w_busy2;
  assign bus.q_fwd_data2  = w_fwd2;
`else
  assign bus.q_fwd_valid1 = 1'b0;
  assign bus.q_fwd_data1  = '0;
  assign bus.q_fwd_valid2 = 1'b0;
  assign bus.q_fwd_data2  = '0;
`endif

endmodule
